booth_seq_mult: RTL and testbench



---
 rtl/booth_pkg.sv | 32 +++
 rtl/booth_r4_digit.sv | 27 ++
 rtl/booth_seq_mult.sv | 120 ++++++++++++
 tb/tb_booth_seq_mult.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier family: FSM states, the
// signed Booth digit code and the triplet-to-digit decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Signed digit code; bit 2 doubles as the "subtract" flag
  typedef logic signed [2:0] booth_digit_t;

  localparam booth_digit_t DIG_ZERO = 3'sb000;
  localparam booth_digit_t DIG_P1   = 3'sb001;
  localparam booth_digit_t DIG_P2   = 3'sb010;
  localparam booth_digit_t DIG_M1   = 3'sb111;
  localparam booth_digit_t DIG_M2   = 3'sb110;

  function automatic booth_digit_t booth_decode(input logic [2:0] trip);
    booth_digit_t d;
    case (trip)
      3'b001, 3'b010: d = DIG_P1;
      3'b011:         d = DIG_P2;
      3'b100:         d = DIG_M2;
      3'b101, 3'b110: d = DIG_M1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth digit: selects 0, A or 2A from a multiplier triplet and
// flags whether the selected multiple must be subtracted.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int EW = 10
) (
  input  logic [2:0]    i_trip,
  input  logic [EW-1:0] i_a,
  output logic [EW-1:0] o_mult,
  output logic          o_neg
);

  booth_digit_t w_dig;

  // 2A is produced modulo 2^EW; callers size EW with enough headroom.
  always_comb begin
    w_dig = booth_decode(i_trip);
    o_neg = w_dig[2];
    case (w_dig)
      DIG_P1, DIG_M1: o_mult = i_a;
      DIG_P2, DIG_M2: o_mult = {i_a[EW-2:0], 1'b0};
      default:        o_mult = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock,
// signed/unsigned per operation, Start/Done handshake.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(NDIG);

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [EW-1:0]        r_a;
  logic [EW:0]          r_b;
  logic [AW-1:0]        r_acc;
  logic [2*WIDTH-1:0]   r_z;

  logic                 w_load;
  logic                 w_last;
  logic [EW-1:0]        w_a_ext;
  logic [EW-1:0]        w_b_ext;
  logic [EW-1:0]        w_mult;
  logic                 w_neg;
  logic [EW-1:0]        w_hi;
  logic [AW-1:0]        w_sum;
  logic [AW-1:0]        w_acc_nxt;

  assign w_a_ext = Signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
  assign w_b_ext = Signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
  assign w_last  = (r_cnt == CW'(NDIG - 1));

  booth_r4_digit #(
    .EW (EW)
  ) u_digit (
    .i_trip (r_b[2:0]),
    .i_a    (r_a),
    .o_mult (w_mult),
    .o_neg  (w_neg)
  );

  // Digit lands at bit EW (= 2*NDIG), so after NDIG shifts-by-2 the
  // accumulator holds the exact product; partial sums never exceed AW-1
  // signed bits, and the low field is untouched by the add.
  assign w_hi      = r_acc[AW-1 -: EW] + (w_neg ? ~w_mult : w_mult) + EW'(w_neg);
  assign w_sum     = {w_hi, r_acc[EW-1:0]};
  assign w_acc_nxt = AW'($signed(w_sum) >>> 2);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_z     <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_a   <= w_a_ext;
        r_b   <= {w_b_ext, 1'b0};
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_acc_nxt;
        r_b   <= {2'b00, r_b[EW:2]};
        if (w_last) begin
          r_z <= w_acc_nxt[2*WIDTH-1:0];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign Z = r_z;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult at WIDTH=8 (directed + random),
// WIDTH=4 (exhaustive, both modes) and WIDTH=16 (random).
module tb_booth_seq_mult;

  logic Clk;
  logic Reset;

  logic        st8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] z8;

  logic        st4, sg4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  z4;

  logic        st16, sg16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] z16;

  int n_checks;
  int n_errors;

  booth_seq_mult #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .Start(st8), .Signed(sg8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Z(z8)
  );

  booth_seq_mult #(.WIDTH(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Start(st4), .Signed(sg4), .A(a4), .B(b4),
    .Busy(busy4), .Done(done4), .Z(z4)
  );

  booth_seq_mult #(.WIDTH(16)) u_dut16 (
    .Clk(Clk), .Reset(Reset), .Start(st16), .Signed(sg16), .A(a16), .B(b16),
    .Busy(busy16), .Done(done16), .Z(z16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer product of the operands as interpreted in the chosen mode.
  function automatic logic [63:0] ref_prod(input int w, input bit sg,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, mask;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Full handshake at WIDTH=8; optionally pokes Start/operands during RUN.
  task automatic mul8(input bit sg, input logic [7:0] a, input logic [7:0] b,
                      input bit poke, input string tag);
    int edges;
    int busy_n;
    logic [63:0] exp;
    exp = ref_prod(8, sg, 32'(a), 32'(b));
    @(negedge Clk);
    st8 = 1'b1; sg8 = sg; a8 = a; b8 = b;
    @(posedge Clk); #1;
    edges = 1; busy_n = 0; st8 = 1'b0;
    while (!done8 && edges < 30) begin
      if (busy8) busy_n++;
      if (poke) begin
        st8 = (edges < 5);
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        sg8 = 1'($urandom);
      end
      @(posedge Clk); #1;
      edges++;
    end
    st8 = 1'b0;
    check({tag, " done"}, 64'(done8), 64'd1);
    check({tag, " latency"}, 64'(edges), 64'd6);
    check({tag, " busy cycles"}, 64'(busy_n), 64'd5);
    check({tag, " z"}, 64'(z8), exp);
    @(posedge Clk); #1;
    check({tag, " single done"}, 64'(done8), 64'd0);
    check({tag, " idle busy"}, 64'(busy8), 64'd0);
    check({tag, " z held"}, 64'(z8), exp);
  endtask

  task automatic mul4(input bit sg, input logic [3:0] a, input logic [3:0] b);
    int n;
    @(negedge Clk);
    st4 = 1'b1; sg4 = sg; a4 = a; b4 = b;
    @(posedge Clk); #1;
    st4 = 1'b0; n = 0;
    while (!done4 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check($sformatf("w4 done s%0d %h*%h", sg, a, b), 64'(done4), 64'd1);
    check($sformatf("w4 z s%0d %h*%h", sg, a, b), 64'(z4), ref_prod(4, sg, 32'(a), 32'(b)));
  endtask

  task automatic mul16(input bit sg, input logic [15:0] a, input logic [15:0] b);
    int n;
    @(negedge Clk);
    st16 = 1'b1; sg16 = sg; a16 = a; b16 = b;
    @(posedge Clk); #1;
    st16 = 1'b0; n = 0;
    while (!done16 && n < 30) begin
      @(posedge Clk); #1;
      n++;
    end
    check($sformatf("w16 done s%0d %h*%h", sg, a, b), 64'(done16), 64'd1);
    check($sformatf("w16 z s%0d %h*%h", sg, a, b), 64'(z16), ref_prod(16, sg, 32'(a), 32'(b)));
  endtask

  initial begin
    int n;
    bit seen;
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    st8 = 1'b0;  sg8 = 1'b0;  a8 = '0;  b8 = '0;
    st4 = 1'b0;  sg4 = 1'b0;  a4 = '0;  b4 = '0;
    st16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset z8", 64'(z8), 64'd0);
    check("reset z16", 64'(z16), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    mul8(1'b0, 8'hFF, 8'hFF, 1'b0, "u ff*ff");
    mul8(1'b1, 8'h80, 8'h80, 1'b0, "s 80*80");
    mul8(1'b1, 8'hFF, 8'h01, 1'b0, "s ff*01");
    mul8(1'b0, 8'hFF, 8'h01, 1'b0, "u ff*01");
    mul8(1'b1, 8'h7F, 8'h80, 1'b0, "s 7f*80");
    mul8(1'b0, 8'h00, 8'hA5, 1'b0, "u 00*a5");
    mul8(1'b1, 8'h5A, 8'hC3, 1'b1, "poke run");
    mul8(1'b0, 8'hC3, 8'h5A, 1'b1, "poke run u");
    for (int i = 0; i < 150; i++) begin
      mul8(1'($urandom), 8'($urandom), 8'($urandom), 1'b0, $sformatf("rand8 #%0d", i));
    end

    // Back-to-back: Start held through DONE with new operands
    @(negedge Clk);
    st8 = 1'b1; sg8 = 1'b0; a8 = 8'h07; b8 = 8'h09;
    @(posedge Clk); #1;
    st8 = 1'b0; n = 0;
    while (!done8 && n < 30) begin
      @(posedge Clk); #1;
      n++;
    end
    check("b2b first z", 64'(z8), 64'h3F);
    st8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
      if (n == 1) begin
        st8 = 1'b0;
        check("b2b accepted", 64'(busy8), 64'd1);
      end
    end while (!done8 && n < 30);
    check("b2b spacing", 64'(n), 64'd6);
    check("b2b second z", 64'(z8), 64'h0F);

    // Reset on the third RUN cycle aborts with no Done
    @(negedge Clk);
    st8 = 1'b1; sg8 = 1'b0; a8 = 8'h5A; b8 = 8'h3C;
    @(posedge Clk); #1;
    st8 = 1'b0;
    repeat (2) begin
      @(posedge Clk); #1;
    end
    check("abort in run", 64'(busy8), 64'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort z", 64'(z8), 64'd0);
    Reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge Clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    check("abort no done", 64'(seen), 64'd0);
    mul8(1'b1, 8'hE7, 8'h19, 1'b0, "after abort");

    // Reset and Start together: Reset wins
    @(negedge Clk);
    Reset = 1'b1; st8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge Clk);
    Reset = 1'b0; st8 = 1'b0;
    @(posedge Clk); #1;
    check("reset beats start", 64'(busy8), 64'd0);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          mul4(s[0], a[3:0], b[3:0]);

    mul16(1'b1, 16'h8000, 16'h8000);
    mul16(1'b0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 1000; i++) begin
      mul16(1'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
